// File: rtl/systolic_pkg.sv
// rtl/systolic_pkg.sv - shared matrix types and FSM states for the systolic job arbiter
package systolic_pkg;

  localparam int N = 4;

  typedef logic [N-1:0][N-1:0][7:0]  matIn_t;
  typedef logic [N-1:0][N-1:0][31:0] matOut_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LAUNCH  = 2'd1,
    WAIT    = 2'd2,
    RESPOND = 2'd3
  } state_t;

endpackage

// File: rtl/systolic_job_arbiter_rr_arb2.sv
// rtl/systolic_job_arbiter_rr_arb2.sv - two-way round-robin grant, one-hot output
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] grant
);

  // A sole requester always wins; on contention the one not granted last wins.
  always_comb begin
    grant = req;
    if (req == 2'b11) begin
      grant = last_grant ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/systolic_job_arbiter.sv
// rtl/systolic_job_arbiter.sv - shares one systolic engine between two requesters, one job at a time
module systolic_job_arbiter
  import systolic_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 31
) (
  input  logic                         i_clk,
  input  logic                         i_arst,
  input  logic [1:0]                   i_reqValid,
  output logic [1:0]                   o_reqReady,
  input  logic [1:0][N-1:0][N-1:0][7:0] i_reqA,
  input  logic [1:0][N-1:0][N-1:0][7:0] i_reqB,
  output logic [1:0]                   o_rspValid,
  input  logic [1:0]                   i_rspReady,
  output logic [N-1:0][N-1:0][31:0]    o_rspC,
  output logic                         o_rspErr,
  output logic [N-1:0][N-1:0][7:0]     o_engA,
  output logic [N-1:0][N-1:0][7:0]     o_engB,
  output logic                         o_engValidInput,
  input  logic [N-1:0][N-1:0][31:0]    i_engC,
  input  logic                         i_engValidResult,
  output logic                         o_busy
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  state_t          state;
  logic            last_grant;
  logic            id_q;
  logic            err_q;
  logic [CW-1:0]   cnt;
  matIn_t          a_q;
  matIn_t          b_q;
  matOut_t         c_q;
  logic [1:0]      grant;
  logic            accept;

  rr_arb2 u_rr_arb2 (
    .req        (i_reqValid),
    .last_grant (last_grant),
    .grant      (grant)
  );

  assign accept          = (state == IDLE) && (|grant);
  assign o_reqReady      = ((state == IDLE) && !i_arst) ? grant : 2'b00;
  assign o_engValidInput = (state == LAUNCH);
  assign o_busy          = (state != IDLE);
  assign o_rspValid      = (state == RESPOND) ? (id_q ? 2'b10 : 2'b01) : 2'b00;
  assign o_rspC          = c_q;
  assign o_rspErr        = err_q;
  assign o_engA          = a_q;
  assign o_engB          = b_q;

  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      id_q       <= 1'b0;
      err_q      <= 1'b0;
      cnt        <= '0;
      a_q        <= '0;
      b_q        <= '0;
      c_q        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_q        <= i_reqA[grant[1]];
            b_q        <= i_reqB[grant[1]];
            id_q       <= grant[1];
            last_grant <= grant[1];
            state      <= LAUNCH;
          end
        end
        LAUNCH: begin
          cnt   <= '0;
          state <= WAIT;
        end
        WAIT: begin
          // A result arriving on the last timeout cycle still counts as success.
          if (i_engValidResult) begin
            c_q   <= i_engC;
            err_q <= 1'b0;
            state <= RESPOND;
          end else if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
            c_q   <= '0;
            err_q <= 1'b1;
            state <= RESPOND;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESPOND: begin
          if (i_rspReady[id_q]) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_systolic_job_arbiter.sv
// tb/tb_systolic_job_arbiter.sv - directed self-checking bench for systolic_job_arbiter
module tb_systolic_job_arbiter;
  import systolic_pkg::*;

  logic                          i_clk = 1'b0;
  logic                          i_arst;
  logic [1:0]                    i_reqValid;
  logic [1:0]                    o_reqReady;
  logic [1:0][N-1:0][N-1:0][7:0] i_reqA;
  logic [1:0][N-1:0][N-1:0][7:0] i_reqB;
  logic [1:0]                    o_rspValid;
  logic [1:0]                    i_rspReady;
  matOut_t                       o_rspC;
  logic                          o_rspErr;
  matIn_t                        o_engA;
  matIn_t                        o_engB;
  logic                          o_engValidInput;
  matOut_t                       i_engC = '0;
  logic                          i_engValidResult = 1'b0;
  logic                          o_busy;

  int checks = 0;
  int errors = 0;

  int   eng_lat = 0;
  int   eng_cnt = 0;
  int   eng_pulses = 0;
  logic spur_on = 1'b0;

  matIn_t  m_id, m_two, m_one, m_zero;
  matOut_t c_two, c_four, c_zero, c_spur;

  systolic_job_arbiter #(.TIMEOUT_CYCLES(31)) dut (
    .i_clk            (i_clk),
    .i_arst           (i_arst),
    .i_reqValid       (i_reqValid),
    .o_reqReady       (o_reqReady),
    .i_reqA           (i_reqA),
    .i_reqB           (i_reqB),
    .o_rspValid       (o_rspValid),
    .i_rspReady       (i_rspReady),
    .o_rspC           (o_rspC),
    .o_rspErr         (o_rspErr),
    .o_engA           (o_engA),
    .o_engB           (o_engB),
    .o_engValidInput  (o_engValidInput),
    .i_engC           (i_engC),
    .i_engValidResult (i_engValidResult),
    .o_busy           (o_busy)
  );

  always #5 i_clk = ~i_clk;

  function automatic matIn_t fill8(input logic [7:0] v);
    matIn_t m;
    for (int i = 0; i < N; i++) for (int j = 0; j < N; j++) m[i][j] = v;
    return m;
  endfunction

  function automatic matOut_t fill32(input logic [31:0] v);
    matOut_t m;
    for (int i = 0; i < N; i++) for (int j = 0; j < N; j++) m[i][j] = v;
    return m;
  endfunction

  function automatic matOut_t matmul(input matIn_t a, input matIn_t b);
    matOut_t c;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        c[i][j] = '0;
        for (int k = 0; k < N; k++) c[i][j] = c[i][j] + 32'(a[i][k]) * 32'(b[k][j]);
      end
    return c;
  endfunction

  // Engine model: result pulse eng_lat cycles after the start pulse; eng_lat=0 never answers.
  always @(negedge i_clk) begin
    logic hit;
    hit = 1'b0;
    if (o_engValidInput) begin
      eng_pulses++;
      if (eng_lat > 0) eng_cnt = eng_lat;
    end else if (eng_cnt > 0) begin
      eng_cnt--;
      if (eng_cnt == 0) hit = 1'b1;
    end
    i_engValidResult = hit | spur_on;
    if (hit) i_engC = matmul(o_engA, o_engB);
    else if (spur_on) i_engC = c_spur;
  end

  task automatic tick();
    @(posedge i_clk);
    #2;
  endtask

  task automatic wait_rsp(inout int t);
    while (o_rspValid == 2'b00 && t < 200) begin
      tick();
      t++;
    end
  endtask

  task automatic run_job(input int id, input matIn_t a, input matIn_t b, output int t);
    int w;
    i_reqA[id] = a;
    i_reqB[id] = b;
    i_reqValid[id] = 1'b1;
    #1;
    w = 0;
    while (!o_reqReady[id] && w < 50) begin
      tick();
      #1;
      w++;
    end
    checks++;
    if (w >= 50) begin
      errors++;
      $display("FAIL accept_wait req%0d got no ready within 50 cycles", id);
    end
    tick();
    i_reqValid[id] = 1'b0;
    t = 1;
    wait_rsp(t);
  endtask

  task automatic consume(input int id);
    i_rspReady[id] = 1'b1;
    tick();
    i_rspReady = 2'b00;
  endtask

  task automatic test_reset();
    i_arst = 1'b1;
    i_reqValid = 2'b11;
    repeat (2) tick();
    #1;
    checks++; if (o_reqReady !== 2'b00) begin errors++; $display("FAIL reset_reqReady got %b exp 00", o_reqReady); end
    checks++; if (o_rspValid !== 2'b00) begin errors++; $display("FAIL reset_rspValid got %b exp 00", o_rspValid); end
    checks++; if (o_engValidInput !== 1'b0) begin errors++; $display("FAIL reset_engValid got %b exp 0", o_engValidInput); end
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", o_busy); end
    checks++; if (o_rspErr !== 1'b0) begin errors++; $display("FAIL reset_rspErr got %b exp 0", o_rspErr); end
    checks++; if (o_rspC !== c_zero) begin errors++; $display("FAIL reset_rspC got %h exp 0", o_rspC); end
    checks++; if (o_engA !== m_zero || o_engB !== m_zero) begin errors++; $display("FAIL reset_engAB got %h / %h exp 0", o_engA, o_engB); end
    i_reqValid = 2'b00;
    tick();
    i_arst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    int t, p0;
    eng_lat = 12;
    p0 = eng_pulses;
    i_reqA[0] = m_id;
    i_reqB[0] = m_two;
    i_reqValid = 2'b01;
    #1;
    checks++; if (o_reqReady !== 2'b01) begin errors++; $display("FAIL basic_ready got %b exp 01", o_reqReady); end
    tick();
    i_reqValid = 2'b00;
    checks++; if (o_engValidInput !== 1'b1 || o_busy !== 1'b1) begin errors++; $display("FAIL basic_launch got engValid=%b busy=%b exp 1 1", o_engValidInput, o_busy); end
    checks++; if (o_engA !== m_id || o_engB !== m_two) begin errors++; $display("FAIL basic_engAB got %h / %h", o_engA, o_engB); end
    t = 1;
    wait_rsp(t);
    checks++; if (t != 14) begin errors++; $display("FAIL basic_latency got %0d exp 14", t); end
    checks++; if (o_rspValid !== 2'b01) begin errors++; $display("FAIL basic_rspValid got %b exp 01", o_rspValid); end
    checks++; if (o_rspC !== c_two || o_rspErr !== 1'b0) begin errors++; $display("FAIL basic_rspC got %h err=%b exp all 2 err=0", o_rspC, o_rspErr); end
    checks++; if (eng_pulses - p0 != 1) begin errors++; $display("FAIL basic_pulses got %0d exp 1", eng_pulses - p0); end
    checks++; if (o_engA !== m_id || o_engValidInput !== 1'b0) begin errors++; $display("FAIL basic_engA_stable got %h engValid=%b", o_engA, o_engValidInput); end
    consume(0);
    checks++; if (o_busy !== 1'b0 || o_rspValid !== 2'b00) begin errors++; $display("FAIL basic_idle got busy=%b rspValid=%b exp 0 00", o_busy, o_rspValid); end
  endtask

  task automatic test_round_robin();
    int t;
    i_arst = 1'b1;
    tick();
    i_arst = 1'b0;
    eng_lat = 2;
    i_reqA[0] = m_id;  i_reqB[0] = m_two;
    i_reqA[1] = m_one; i_reqB[1] = m_one;
    i_reqValid = 2'b11;
    #1;
    checks++; if (o_reqReady !== 2'b01) begin errors++; $display("FAIL rr_first_ready got %b exp 01", o_reqReady); end
    tick();
    checks++; if (o_reqReady !== 2'b00) begin errors++; $display("FAIL rr_busy_ready got %b exp 00", o_reqReady); end
    t = 1; wait_rsp(t);
    checks++; if (o_rspValid !== 2'b01 || o_rspC !== c_two) begin errors++; $display("FAIL rr_job1 got rspValid=%b C=%h", o_rspValid, o_rspC); end
    consume(0);
    #1;
    checks++; if (o_reqReady !== 2'b10) begin errors++; $display("FAIL rr_second_ready got %b exp 10", o_reqReady); end
    tick();
    t = 1; wait_rsp(t);
    checks++; if (o_rspValid !== 2'b10 || o_rspC !== c_four) begin errors++; $display("FAIL rr_job2 got rspValid=%b C=%h", o_rspValid, o_rspC); end
    consume(1);
    #1;
    checks++; if (o_reqReady !== 2'b01) begin errors++; $display("FAIL rr_third_ready got %b exp 01", o_reqReady); end
    tick();
    i_reqValid = 2'b00;
    t = 1; wait_rsp(t);
    checks++; if (o_rspValid !== 2'b01 || o_rspC !== c_two) begin errors++; $display("FAIL rr_job3 got rspValid=%b C=%h", o_rspValid, o_rspC); end
    consume(0);
  endtask

  task automatic test_backpressure();
    int t;
    eng_lat = 2;
    run_job(0, m_id, m_two, t);
    i_reqValid = 2'b10;
    i_rspReady = 2'b10;
    for (int k = 0; k < 5; k++) begin
      tick();
      checks++;
      if (o_rspValid !== 2'b01 || o_rspC !== c_two || o_reqReady !== 2'b00) begin
        errors++;
        $display("FAIL bp_hold cycle %0d got rspValid=%b reqReady=%b C=%h", k, o_rspValid, o_reqReady, o_rspC);
      end
    end
    i_reqValid = 2'b00;
    i_rspReady = 2'b00;
    consume(0);
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL bp_release got busy=%b exp 0", o_busy); end
  endtask

  task automatic test_timeout();
    int t;
    eng_lat = 0;
    run_job(0, m_id, m_two, t);
    checks++; if (t != 33) begin errors++; $display("FAIL to_latency got %0d exp 33", t); end
    checks++; if (o_rspErr !== 1'b1 || o_rspC !== c_zero || o_rspValid !== 2'b01) begin errors++; $display("FAIL to_result got err=%b rspValid=%b C=%h", o_rspErr, o_rspValid, o_rspC); end
    consume(0);
  endtask

  task automatic test_timeout_edge();
    int t;
    eng_lat = 31;
    run_job(0, m_id, m_two, t);
    checks++; if (t != 33) begin errors++; $display("FAIL edge_latency got %0d exp 33", t); end
    checks++; if (o_rspErr !== 1'b0 || o_rspC !== c_two) begin errors++; $display("FAIL edge_result got err=%b C=%h", o_rspErr, o_rspC); end
    consume(0);
    eng_lat = 0;
    spur_on = 1'b1;
    tick();
    spur_on = 1'b0;
    repeat (3) tick();
    checks++;
    if (o_busy !== 1'b0 || o_rspValid !== 2'b00 || o_rspC !== c_two || o_rspErr !== 1'b0) begin
      errors++;
      $display("FAIL spurious got busy=%b rspValid=%b err=%b C=%h", o_busy, o_rspValid, o_rspErr, o_rspC);
    end
  endtask

  task automatic test_reset_mid_wait();
    int t;
    eng_lat = 20;
    i_reqA[0] = m_id;
    i_reqB[0] = m_two;
    i_reqValid = 2'b01;
    #1;
    tick();
    i_reqValid = 2'b00;
    repeat (5) tick();
    i_arst = 1'b1;
    i_reqValid = 2'b11;
    #1;
    checks++;
    if (o_busy !== 1'b0 || o_rspValid !== 2'b00 || o_engValidInput !== 1'b0 || o_rspErr !== 1'b0 || o_reqReady !== 2'b00) begin
      errors++;
      $display("FAIL mid_reset_ctrl got busy=%b rspValid=%b engValid=%b err=%b reqReady=%b", o_busy, o_rspValid, o_engValidInput, o_rspErr, o_reqReady);
    end
    checks++; if (o_rspC !== c_zero || o_engA !== m_zero || o_engB !== m_zero) begin errors++; $display("FAIL mid_reset_data got C=%h A=%h B=%h", o_rspC, o_engA, o_engB); end
    tick();
    i_reqValid = 2'b00;
    tick();
    i_arst = 1'b0;
    repeat (20) tick();
    checks++; if (o_busy !== 1'b0 || o_rspValid !== 2'b00 || o_rspC !== c_zero) begin errors++; $display("FAIL late_result got busy=%b rspValid=%b C=%h", o_busy, o_rspValid, o_rspC); end
    eng_lat = 3;
    run_job(1, m_one, m_one, t);
    checks++; if (t != 5) begin errors++; $display("FAIL post_reset_latency got %0d exp 5", t); end
    checks++; if (o_rspValid !== 2'b10 || o_rspC !== c_four || o_rspErr !== 1'b0) begin errors++; $display("FAIL post_reset_job got rspValid=%b err=%b C=%h", o_rspValid, o_rspErr, o_rspC); end
    consume(1);
  endtask

  initial begin
    m_zero = fill8(8'd0);
    m_two  = fill8(8'd2);
    m_one  = fill8(8'd1);
    m_id   = m_zero;
    for (int i = 0; i < N; i++) m_id[i][i] = 8'd1;
    c_zero = fill32(32'd0);
    c_two  = fill32(32'd2);
    c_four = fill32(32'd4);
    c_spur = fill32(32'd99);
    i_arst     = 1'b1;
    i_reqValid = 2'b00;
    i_rspReady = 2'b00;
    i_reqA     = '0;
    i_reqB     = '0;

    test_reset();
    test_basic();
    test_round_robin();
    test_backpressure();
    test_timeout();
    test_timeout_edge();
    test_reset_mid_wait();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/systolic_job_arbiter.md
SYSTOLIC_JOB_ARBITER -- requirements
Module: systolic_job_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 31: maximum cycles in WAIT before an error response.
REQ-002 i_clk  input  1  clock; all state updates on posedge.
REQ-003 i_arst  input  1  reset, asynchronous, active-high.
REQ-004 i_reqValid  input  [1:0]  per-requester job request.
REQ-005 o_reqReady  output  [1:0]  per-requester accept.
REQ-006 i_reqA, i_reqB  input  [1:0][3:0][3:0][7:0]  per-requester operand matrices.
REQ-007 o_rspValid  output  [1:0]  result valid, one-hot to the owning requester.
REQ-008 i_rspReady  input  [1:0]  per-requester result accept.
REQ-009 o_rspC  output  [3:0][3:0][31:0]  shared result bus.
REQ-010 o_rspErr  output  1  result is a timeout error; qualified by o_rspValid.
REQ-011 o_engA, o_engB  output  [3:0][3:0][7:0]  operands to the systolic engine.
REQ-012 o_engValidInput  output  1  single-cycle engine start pulse.
REQ-013 i_engC  input  [3:0][3:0][31:0]  engine result.
REQ-014 i_engValidResult  input  1  engine result-valid pulse.
REQ-015 o_busy  output  1  high in every state except IDLE.

Function
REQ-016 The FSM SHALL have states IDLE, LAUNCH, WAIT, RESPOND.
REQ-017 IDLE: the grant SHALL be round-robin; a sole requester wins; when both are valid, the requester not granted last wins.
REQ-018 IDLE: o_reqReady SHALL be asserted combinationally for the granted requester only; 0 in every other state.
REQ-019 On accept (valid & ready): capture A/B and the grant ID, update the last-grant register, go to LAUNCH.
REQ-020 LAUNCH (exactly 1 cycle): o_engValidInput=1, then go to WAIT; the pulse is 0 in every other state.
REQ-021 o_engA/o_engB SHALL be driven from the captured registers and stay stable from LAUNCH until return to IDLE.
REQ-022 WAIT: the timeout counter SHALL count from 0 each cycle; on i_engValidResult, capture i_engC, clear the error flag, go to RESPOND.
REQ-023 WAIT: when the counter reaches TIMEOUT_CYCLES-1 with no result, set the error flag, set the captured C to 0, go to RESPOND.
REQ-024 If a result and the timeout occur in the same cycle, the result SHALL win (no error).
REQ-025 i_engValidResult outside WAIT SHALL be ignored.
REQ-026 RESPOND: o_rspValid[id]=1 with o_rspC/o_rspErr held stable until i_rspReady[id]; then go to IDLE; the other i_rspReady bit is ignored.
REQ-027 Only one job SHALL be outstanding; with an immediately ready engine and consumer, job latency is engine latency + 3 cycles (accept, LAUNCH, RESPOND).
REQ-028 A requester deasserting i_reqValid before accept SHALL cause no state change.

Reset
REQ-029 On i_arst: state=IDLE, last-grant=1 (requester 0 wins first), counter=0, captured A/B/C=0, error flag=0.
REQ-030 Output values in reset: o_reqReady=0 while i_arst is high, o_rspValid=0, o_engValidInput=0, o_busy=0, o_rspErr=0, o_rspC=0, o_engA/B=0.
REQ-031 Reset mid-job SHALL abandon the job silently; a late engine result after reset is ignored per REQ-025.

Structure
REQ-032 Package systolic_pkg SHALL hold N=4, matIn_t ([3:0][3:0][7:0]), matOut_t ([3:0][3:0][31:0]) and the FSM state enum.
REQ-033 The two-way round-robin grant SHALL be a sub-module rr_arb2 (inputs: request and last-grant; output: one-hot grant).
REQ-034 TIMEOUT_CYCLES SHALL be a module parameter; the counter width is $clog2(TIMEOUT_CYCLES+1).

Verification
REQ-035 Req0 with A=identity and B=all 8'd2, engine model with 12-cycle latency -> one o_engValidInput pulse; o_rspValid=2'b01 and o_rspC all 32'd2 with err=0.
REQ-036 Both requesters valid from reset -> req0 served first, then req1; a third back-to-back request from both -> req0 served again (alternation).
REQ-037 i_rspReady low for 5 cycles in RESPOND -> o_rspValid/o_rspC stable; o_reqReady=0 throughout.
REQ-038 Engine never responds -> exactly 31 cycles in WAIT, then o_rspErr=1 and o_rspC=0.
REQ-039 Engine result on the final timeout cycle -> err=0 and the correct C; a spurious i_engValidResult in IDLE -> no output change.
REQ-040 i_arst asserted mid-WAIT -> all outputs at reset values; a late result pulse after reset is ignored; the next request is served normally.
